// File: rtl/bht_controller.sv
// Branch history table controller: a table of 2-bit saturating counters
// (00 StrongTaken .. 11 StrongNotTaken) behind one shared access port.
// Fetch lookups and queued resolve-stage updates take turns on that port.
//
// state | meaning
// ------+----------------------------------------------------------------
// INIT  | clearing sweep, one entry per cycle; lookups/updates ignored
// RUN   | serving lookups, draining the 2-entry update queue
module bht_controller #(
    parameter int IDX_W = 4,
    parameter int PC_W  = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            lookup_req,
    input  logic [PC_W-1:0] lookup_pc,
    output logic            stall_fetch,
    output logic            pred_valid,
    output logic            pred_taken,
    input  logic            upd_valid,
    input  logic [PC_W-1:0] upd_pc,
    input  logic            upd_br,
    input  logic            upd_taken,
    output logic            upd_full,
    input  logic            flush_tbl,
    output logic            init_busy,
    output logic            ovf_err
);

    localparam int DEPTH = 1 << IDX_W;

    typedef enum logic {ST_INIT, ST_RUN} state_e;

    state_e           state_q, state_d;
    logic [IDX_W-1:0] init_idx_q, init_idx_d;
    logic [1:0]       count_q, count_d;
    logic [IDX_W-1:0] q0_idx_q, q0_idx_d, q1_idx_q, q1_idx_d;
    logic             q0_tkn_q, q0_tkn_d, q1_tkn_q, q1_tkn_d;
    logic             pred_valid_q, pred_valid_d;
    logic             pred_taken_q, pred_taken_d;
    logic             ovf_err_q, ovf_err_d;

    logic [1:0]       tbl_q [DEPTH];
    logic             tbl_we;
    logic [IDX_W-1:0] tbl_waddr;
    logic [1:0]       tbl_wdata;

    logic [IDX_W-1:0] lk_idx, up_idx;
    logic [1:0]       head_ctr, head_next;
    logic             pop, push;
    logic [1:0]       cnt_after;

    assign lk_idx   = lookup_pc[IDX_W-1:0];
    assign up_idx   = upd_pc[IDX_W-1:0];
    assign head_ctr = tbl_q[q0_idx_q];

    // Saturating step of the queue-head counter: taken moves toward 00.
    always_comb begin
        head_next = head_ctr;
        if (q0_tkn_q) begin
            if (head_ctr != 2'b00) head_next = head_ctr - 2'b01;
        end else begin
            if (head_ctr != 2'b11) head_next = head_ctr + 2'b01;
        end
    end

    // Enqueue looks at the registered count so a new entry waits a cycle.
    assign push = (state_q == ST_RUN) && upd_valid && upd_br &&
                  (count_q != 2'd2) && !flush_tbl;

    // Next-state, port arbitration and queue bookkeeping.
    always_comb begin
        state_d      = state_q;
        init_idx_d   = init_idx_q;
        count_d      = count_q;
        q0_idx_d     = q0_idx_q;
        q0_tkn_d     = q0_tkn_q;
        q1_idx_d     = q1_idx_q;
        q1_tkn_d     = q1_tkn_q;
        pred_valid_d = 1'b0;
        pred_taken_d = pred_taken_q;
        ovf_err_d    = ovf_err_q;
        tbl_we       = 1'b0;
        tbl_waddr    = init_idx_q;
        tbl_wdata    = 2'b00;
        pop          = 1'b0;

        case (state_q)
            ST_INIT: begin
                tbl_we     = 1'b1;
                tbl_waddr  = init_idx_q;
                tbl_wdata  = 2'b00;
                init_idx_d = init_idx_q + 1'b1;
                if (&init_idx_q) state_d = ST_RUN;
            end
            ST_RUN: begin
                // A full queue outranks fetch so resolve never stalls forever.
                if (count_q == 2'd2) begin
                    pop = 1'b1;
                end else if (lookup_req) begin
                    pred_valid_d = 1'b1;
                    pred_taken_d = ~tbl_q[lk_idx][1];
                end else if (count_q != 2'd0) begin
                    pop = 1'b1;
                end
                if (pop) begin
                    tbl_we    = 1'b1;
                    tbl_waddr = q0_idx_q;
                    tbl_wdata = head_next;
                end
                if (upd_valid && upd_br && (count_q == 2'd2)) ovf_err_d = 1'b1;
            end
            default: state_d = ST_INIT;
        endcase

        if (pop) begin
            q0_idx_d = q1_idx_q;
            q0_tkn_d = q1_tkn_q;
        end
        cnt_after = count_q - {1'b0, pop};
        if (push) begin
            if (cnt_after == 2'd0) begin
                q0_idx_d = up_idx;
                q0_tkn_d = upd_taken;
            end else begin
                q1_idx_d = up_idx;
                q1_tkn_d = upd_taken;
            end
        end
        count_d = cnt_after + {1'b0, push};

        // Flush wins over everything except the sticky overflow flag.
        if (flush_tbl) begin
            state_d      = ST_INIT;
            init_idx_d   = '0;
            count_d      = 2'd0;
            pred_valid_d = 1'b0;
            pred_taken_d = pred_taken_q;
            tbl_we       = 1'b0;
        end
    end

    // Control and queue registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_INIT;
            init_idx_q   <= '0;
            count_q      <= 2'd0;
            q0_idx_q     <= '0;
            q0_tkn_q     <= 1'b0;
            q1_idx_q     <= '0;
            q1_tkn_q     <= 1'b0;
            pred_valid_q <= 1'b0;
            pred_taken_q <= 1'b0;
            ovf_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            init_idx_q   <= init_idx_d;
            count_q      <= count_d;
            q0_idx_q     <= q0_idx_d;
            q0_tkn_q     <= q0_tkn_d;
            q1_idx_q     <= q1_idx_d;
            q1_tkn_q     <= q1_tkn_d;
            pred_valid_q <= pred_valid_d;
            pred_taken_q <= pred_taken_d;
            ovf_err_q    <= ovf_err_d;
        end
    end

    // Counter storage; contents are established by the INIT sweep.
    always_ff @(posedge clk) begin
        if (tbl_we) tbl_q[tbl_waddr] <= tbl_wdata;
    end

    assign init_busy   = (state_q == ST_INIT);
    assign stall_fetch = init_busy || (count_q == 2'd2);
    assign upd_full    = init_busy || (count_q == 2'd2);
    assign pred_valid  = pred_valid_q;
    assign pred_taken  = pred_taken_q;
    assign ovf_err     = ovf_err_q;

endmodule

// File: tb/tb_bht_controller.sv
module tb_bht_controller;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        lookup_req = 1'b0;
    logic [15:0] lookup_pc = '0;
    logic        stall_fetch, pred_valid, pred_taken;
    logic        upd_valid = 1'b0;
    logic [15:0] upd_pc = '0;
    logic        upd_br = 1'b0;
    logic        upd_taken = 1'b0;
    logic        upd_full, init_busy, ovf_err;
    logic        flush_tbl = 1'b0;

    int checks = 0;
    int errors = 0;

    logic [1:0] m_tbl [16];
    logic       exp_q [$];

    bht_controller #(.IDX_W(4), .PC_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .lookup_req(lookup_req), .lookup_pc(lookup_pc),
        .stall_fetch(stall_fetch), .pred_valid(pred_valid), .pred_taken(pred_taken),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_br(upd_br), .upd_taken(upd_taken),
        .upd_full(upd_full), .flush_tbl(flush_tbl), .init_busy(init_busy), .ovf_err(ovf_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    function automatic logic [1:0] step_ctr(input logic [1:0] c, input logic t);
        if (t) return (c == 2'b00) ? 2'b00 : c - 2'b01;
        return (c == 2'b11) ? 2'b11 : c + 2'b01;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 16; i++) m_tbl[i] = 2'b00;
    endtask

    task automatic lookup(input logic [15:0] pc);
        exp_q.push_back(~m_tbl[pc[3:0]][1]);
        lookup_req = 1'b1;
        lookup_pc  = pc;
        tick();
        lookup_req = 1'b0;
        tick();
    endtask

    task automatic update(input logic [15:0] pc, input logic br, input logic t, input logic apply);
        upd_valid = 1'b1;
        upd_pc    = pc;
        upd_br    = br;
        upd_taken = t;
        tick();
        upd_valid = 1'b0;
        if (apply && br) m_tbl[pc[3:0]] = step_ctr(m_tbl[pc[3:0]], t);
    endtask

    task automatic check_init_sweep(input string tag);
        for (int i = 0; i < 16; i++) begin
            check({tag, "_busy"}, int'(init_busy), 1);
            check({tag, "_stall"}, int'(stall_fetch), 1);
            tick();
        end
        check({tag, "_done"}, int'(init_busy), 0);
    endtask

    // Scoreboard: every prediction must match the oldest expected value.
    always @(negedge clk) begin
        if (rst_n && pred_valid) begin
            checks++;
            assert (exp_q.size() > 0) else begin
                errors++;
                $error("FAIL pred_spurious observed pred_valid=1 expected no prediction");
            end
            if (exp_q.size() > 0) check("pred_taken", int'(pred_taken), int'(exp_q.pop_front()));
        end
    end

    initial begin
        model_clear();

        // Reset values
        idle(2);
        check("rst_pred_valid", int'(pred_valid), 0);
        check("rst_pred_taken", int'(pred_taken), 0);
        check("rst_stall", int'(stall_fetch), 1);
        check("rst_init_busy", int'(init_busy), 1);
        check("rst_upd_full", int'(upd_full), 1);
        check("rst_ovf", int'(ovf_err), 0);

        // INIT sweep ignores lookups and updates
        rst_n      = 1'b1;
        lookup_req = 1'b1;
        lookup_pc  = 16'h0005;
        upd_valid  = 1'b1;
        upd_pc     = 16'h0005;
        upd_br     = 1'b1;
        upd_taken  = 1'b0;
        check_init_sweep("init");
        lookup_req = 1'b0;
        upd_valid  = 1'b0;
        check("init_stall_off", int'(stall_fetch), 0);
        check("init_upd_full_off", int'(upd_full), 0);
        check("init_ovf", int'(ovf_err), 0);
        lookup(16'h0005);

        // Counter walk on idx 3
        update(16'h0003, 1'b1, 1'b0, 1'b1);
        update(16'h0003, 1'b1, 1'b0, 1'b1);
        idle(3);
        lookup(16'h0013);
        update(16'h0003, 1'b1, 1'b0, 1'b1);
        idle(3);
        lookup(16'h0003);
        update(16'h0003, 1'b1, 1'b1, 1'b1);
        idle(3);
        lookup(16'h0003);
        update(16'h0003, 1'b1, 1'b1, 1'b1);
        idle(3);
        lookup(16'h0003);

        // Saturation on idx 0
        for (int i = 0; i < 3; i++) update(16'h0000, 1'b1, 1'b1, 1'b1);
        idle(3);
        lookup(16'h0000);
        for (int i = 0; i < 5; i++) update(16'h0000, 1'b1, 1'b0, 1'b1);
        idle(3);
        lookup(16'h0000);
        update(16'h0000, 1'b1, 1'b1, 1'b1);
        idle(3);
        lookup(16'h0000);

        // Non-branch updates are filtered
        update(16'h0002, 1'b0, 1'b0, 1'b1);
        check("nonbr_upd_full", int'(upd_full), 0);
        idle(1);
        check("nonbr_upd_full2", int'(upd_full), 0);
        lookup(16'h0002);

        // Back-pressure and overflow
        lookup_req = 1'b1;
        lookup_pc  = 16'h0007;
        exp_q.push_back(~m_tbl[7][1]);
        upd_valid = 1'b1; upd_pc = 16'h0005; upd_br = 1'b1; upd_taken = 1'b0;
        tick();
        check("bp_stall_c1", int'(stall_fetch), 0);
        exp_q.push_back(~m_tbl[7][1]);
        tick();
        m_tbl[5] = step_ctr(m_tbl[5], 1'b0);
        m_tbl[5] = step_ctr(m_tbl[5], 1'b0);
        check("bp_stall_full", int'(stall_fetch), 1);
        check("bp_upd_full", int'(upd_full), 1);
        upd_pc = 16'h0006;
        tick();
        upd_valid = 1'b0;
        check("bp_no_pred", int'(pred_valid), 0);
        check("bp_stall_drop", int'(stall_fetch), 0);
        check("bp_ovf_set", int'(ovf_err), 1);
        exp_q.push_back(~m_tbl[7][1]);
        tick();
        lookup_req = 1'b0;
        idle(4);
        check("bp_ovf_sticky", int'(ovf_err), 1);
        check("bp_drained", int'(upd_full), 0);
        lookup(16'h0006);
        lookup(16'h0005);

        // Flush with a pending update
        update(16'h0004, 1'b1, 1'b0, 1'b0);
        flush_tbl = 1'b1;
        tick();
        flush_tbl = 1'b0;
        model_clear();
        check_init_sweep("flush");
        check("flush_q_empty", int'(upd_full), 0);
        lookup(16'h0004);
        lookup(16'h0005);
        check("flush_ovf_kept", int'(ovf_err), 1);

        // Async reset mid-operation
        update(16'h0001, 1'b1, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check("arst_busy", int'(init_busy), 1);
        check("arst_ovf", int'(ovf_err), 0);
        check("arst_pred_taken", int'(pred_taken), 0);

        idle(2);
        check("pred_pending", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL timeout observed no finish expected finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "timeout");
    end

endmodule
